// File: rtl/conv2d_pe_pkg.sv
// conv2d_pe_pkg: shared types, sizing helpers and the quantize/saturate
// function for the conv2d_pe processing element.
// Optional macro CONV2D_PE_SIGNED_EN selects two's-complement arithmetic.
package conv2d_pe_pkg;

  localparam int unsigned DATA_W  = 32;
  // Wide enough to hold any accumulator this PE can build, so a single
  // quantize function serves every parameterisation.
  localparam int unsigned QUANT_W = 128;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {COMPUTE = 1'b0} state_t;

  // 64-bit products plus headroom for summing every tap of the window.
  function automatic int unsigned acc_width(input int unsigned taps);
    return 64 + $clog2(taps);
  endfunction

  // Minimum index width for an array dimension (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ACC_W_DEFAULT = acc_width(3 * 3 * 1);
  typedef logic [ACC_W_DEFAULT-1:0] acc_t;

`ifdef CONV2D_PE_SIGNED_EN
  // Shift only when |acc| exceeds the threshold, then clamp to int32 range.
  function automatic data_t quantize(input logic signed [QUANT_W-1:0] acc,
                                     input data_t thr,
                                     input logic [5:0] sh);
    logic signed [QUANT_W-1:0] mag;
    logic signed [QUANT_W-1:0] thr_ext;
    logic signed [QUANT_W-1:0] q;
    logic signed [QUANT_W-1:0] smax;
    logic signed [QUANT_W-1:0] smin;
    smax    = $signed({{(QUANT_W-DATA_W){1'b0}}, 32'h7FFF_FFFF});
    smin    = $signed({{(QUANT_W-DATA_W){1'b1}}, 32'h8000_0000});
    thr_ext = $signed({{(QUANT_W-DATA_W){1'b0}}, thr});
    mag     = acc[QUANT_W-1] ? -acc : acc;
    q       = (mag > thr_ext) ? (acc >>> sh) : acc;
    if (q > smax)      return 32'h7FFF_FFFF;
    else if (q < smin) return 32'h8000_0000;
    else               return q[DATA_W-1:0];
  endfunction
`else
  // Shift only when acc exceeds the threshold, then clamp to 32 bits.
  function automatic data_t quantize(input logic [QUANT_W-1:0] acc,
                                     input data_t thr,
                                     input logic [5:0] sh);
    logic [QUANT_W-1:0] q;
    q = (acc > QUANT_W'(thr)) ? (acc >> sh) : acc;
    return (|q[QUANT_W-1:DATA_W]) ? '1 : q[DATA_W-1:0];
  endfunction
`endif

endpackage

// File: rtl/conv2d_pe_dot.sv
// conv2d_pe_dot: combinational Kh x Kw x Cin dot product for one output
// element (column X, channel CO) of the selected row, with zero padding
// and quantization. Honours CONV2D_PE_SIGNED_EN via the package.
module conv2d_pe_dot
  import conv2d_pe_pkg::*;
#(
  parameter int unsigned Hout  = 5,
  parameter int unsigned Wout  = 5,
  parameter int unsigned Cin   = 1,
  parameter int unsigned Cout  = 2,
  parameter int unsigned Kh    = 3,
  parameter int unsigned Kw    = 3,
  parameter int unsigned ROW_W = 3,
  parameter int unsigned X     = 0,
  parameter int unsigned CO    = 0
) (
  input  data_t            act [Hout][Wout][Cin],
  input  data_t            wt  [Kh][Kw][Cin][Cout],
  input  logic [ROW_W-1:0] row,
  input  data_t            thr,
  input  logic [5:0]       shift,
  output data_t            result
);

  localparam int unsigned ACC_W = acc_width(Kh * Kw * Cin);
  localparam int unsigned HI_W  = idx_w(Hout);
  localparam int unsigned WI_W  = idx_w(Wout);
  localparam int unsigned CI_W  = idx_w(Cin);
  localparam int unsigned KY_W  = idx_w(Kh);
  localparam int unsigned KX_W  = idx_w(Kw);
  localparam int unsigned CO_W  = idx_w(Cout);

`ifdef CONV2D_PE_SIGNED_EN
  logic signed [ACC_W-1:0] acc;
  logic signed [63:0]      prod;
`else
  logic [ACC_W-1:0]        acc;
  logic [63:0]             prod;
`endif
  data_t a;
  data_t w;
  int    iy;
  int    ix;

  // Sum in-range taps of the window centred on (row, X); then quantize.
  always_comb begin
    acc  = '0;
    prod = '0;
    a    = '0;
    w    = '0;
    iy   = 0;
    ix   = 0;
    for (int unsigned ky = 0; ky < Kh; ky++) begin
      for (int unsigned kx = 0; kx < Kw; kx++) begin
        iy = int'(row) + int'(ky) - int'(Kh / 2);
        ix = int'(X) + int'(kx) - int'(Kw / 2);
        if (iy >= 0 && iy < int'(Hout) && ix >= 0 && ix < int'(Wout)) begin
          for (int unsigned ci = 0; ci < Cin; ci++) begin
            a = act[HI_W'(iy)][WI_W'(ix)][CI_W'(ci)];
            w = wt[KY_W'(ky)][KX_W'(kx)][CI_W'(ci)][CO_W'(CO)];
`ifdef CONV2D_PE_SIGNED_EN
            prod = 64'($signed(a)) * 64'($signed(w));
`else
            prod = 64'(a) * 64'(w);
`endif
            acc = acc + ACC_W'(prod);
          end
        end
      end
    end
    result = quantize(QUANT_W'(acc), thr, shift);
  end

endmodule

// File: rtl/conv2d_pe.sv
// conv2d_pe: free-running stride-1 "same"-padded 2-D convolution PE.
// Writes one output row (Wout x Cout elements) per clock, wraps over the
// frame and pulses frame_done on the last row.
// Optional macro CONV2D_PE_SIGNED_EN: two's-complement arithmetic.
module conv2d_pe
  import conv2d_pe_pkg::*;
#(
  parameter int unsigned N    = 1,
  parameter int unsigned Hout = 5,
  parameter int unsigned Wout = 5,
  parameter int unsigned Cin  = 1,
  parameter int unsigned Cout = 2,
  parameter int unsigned Kh   = 3,
  parameter int unsigned Kw   = 3
) (
  input  logic  clk,
  input  logic  reset,
  input  data_t input_activations [N][Hout][Wout][Cin],
  input  data_t weights [Kh][Kw][Cin][Cout],
  input  data_t quantization_threshold,
  input  data_t m,
  output data_t conv_output [Hout][Wout][Cout],
  output logic  frame_done
);

  localparam int unsigned ROW_W = idx_w(Hout);
  localparam int unsigned COL_W = idx_w(Wout);
  localparam int unsigned CO_W  = idx_w(Cout);

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic             last_row;
  data_t            act0 [Hout][Wout][Cin];
  data_t            dot_out [Wout][Cout];
  logic             unused_m_hi;

  // Only batch 0 is convolved; only m[5:0] is a meaningful shift amount.
  assign act0        = input_activations[0];
  assign last_row    = (row_q == ROW_W'(Hout - 1));
  assign unused_m_hi = ^m[DATA_W-1:6];

  for (genvar gx = 0; gx < Wout; gx++) begin : g_col
    for (genvar gc = 0; gc < Cout; gc++) begin : g_och
      conv2d_pe_dot #(
        .Hout (Hout),
        .Wout (Wout),
        .Cin  (Cin),
        .Cout (Cout),
        .Kh   (Kh),
        .Kw   (Kw),
        .ROW_W(ROW_W),
        .X    (gx),
        .CO   (gc)
      ) u_dot (
        .act   (act0),
        .wt    (weights),
        .row   (row_q),
        .thr   (quantization_threshold),
        .shift (m[5:0]),
        .result(dot_out[gx][gc])
      );
    end
  end

  // Row sequencer: commit current row, advance pointer, flag the last row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COMPUTE;
      row_q       <= '0;
      frame_done  <= 1'b0;
      conv_output <= '{default: '0};
    end else begin
      state_q <= COMPUTE;
      if (state_q == COMPUTE) begin
        for (int unsigned x = 0; x < Wout; x++) begin
          for (int unsigned co = 0; co < Cout; co++) begin
            conv_output[row_q][COL_W'(x)][CO_W'(co)] <= dot_out[COL_W'(x)][CO_W'(co)];
          end
        end
        frame_done <= last_row;
        row_q      <= last_row ? '0 : row_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_pe.sv
// tb_conv2d_pe: randomized and directed checks of conv2d_pe (default
// unsigned build) against a direct arithmetic model of the convolution.
module tb_conv2d_pe;

  localparam int N  = 1;
  localparam int H  = 5;
  localparam int W  = 5;
  localparam int CI = 1;
  localparam int CO = 2;
  localparam int KH = 3;
  localparam int KW = 3;

  logic        clk;
  logic        reset;
  logic [31:0] input_activations [N][H][W][CI];
  logic [31:0] weights [KH][KW][CI][CO];
  logic [31:0] quantization_threshold;
  logic [31:0] m;
  logic [31:0] conv_output [H][W][CO];
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_old [H][W][CO];

  conv2d_pe #(
    .N(N), .Hout(H), .Wout(W), .Cin(CI), .Cout(CO), .Kh(KH), .Kw(KW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .input_activations     (input_activations),
    .weights               (weights),
    .quantization_threshold(quantization_threshold),
    .m                     (m),
    .conv_output           (conv_output),
    .frame_done            (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: direct sum over the padded window, then threshold/shift/clamp.
  function automatic logic [31:0] ref_elem(int y, int x, int co);
    logic [127:0] sum;
    logic [127:0] q;
    int ay, ax;
    sum = '0;
    for (int ky = 0; ky < KH; ky++)
      for (int kx = 0; kx < KW; kx++)
        for (int ci = 0; ci < CI; ci++) begin
          ay = y + ky - KH / 2;
          ax = x + kx - KW / 2;
          if (ay >= 0 && ay < H && ax >= 0 && ax < W)
            sum += 128'(input_activations[0][ay][ax][ci]) * 128'(weights[ky][kx][ci][co]);
        end
    q = (sum > 128'(quantization_threshold)) ? (sum >> m[5:0]) : sum;
    return (q > 128'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  task automatic set_ramp();
    for (int j = 0; j < H; j++)
      for (int k = 0; k < W; k++)
        input_activations[0][j][k][0] = 32'(1 + 5 * j + k);
    for (int ky = 0; ky < KH; ky++)
      for (int kx = 0; kx < KW; kx++) begin
        weights[ky][kx][0][0] = 32'd1;
        weights[ky][kx][0][1] = 32'd0;
      end
    quantization_threshold = 32'hFFFF_FFFF;
    m = 32'd0;
  endtask

  task automatic set_random_acts(input bit wide);
    for (int j = 0; j < H; j++)
      for (int k = 0; k < W; k++)
        for (int c = 0; c < CI; c++)
          input_activations[0][j][k][c] = wide ? $urandom : $urandom_range(0, 255);
  endtask

  task automatic set_random(input bit wide);
    set_random_acts(wide);
    for (int ky = 0; ky < KH; ky++)
      for (int kx = 0; kx < KW; kx++)
        for (int c = 0; c < CI; c++)
          for (int o = 0; o < CO; o++)
            weights[ky][kx][c][o] = wide ? $urandom : $urandom_range(0, 255);
    quantization_threshold = wide ? $urandom : $urandom_range(0, 3000);
    m = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset();
    set_random(1'b0);
    do_reset();
    repeat (H + 1) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++) begin
          checks++;
          if (conv_output[y][x][o] !== 32'd0) begin
            errors++;
            $display("FAIL reset_out(%0d,%0d,%0d): got %h expected 0", y, x, o, conv_output[y][x][o]);
          end
        end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done: got %b expected 0", frame_done);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_ramp();
    set_ramp();
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (conv_output[2][2][0] !== 32'h75) begin
      errors++; $display("FAIL ramp_center: got %h expected 75", conv_output[2][2][0]);
    end
    checks++;
    if (conv_output[0][0][0] !== 32'h10) begin
      errors++; $display("FAIL ramp_corner00: got %h expected 10", conv_output[0][0][0]);
    end
    checks++;
    if (conv_output[0][1][0] !== 32'h1b) begin
      errors++; $display("FAIL ramp_edge01: got %h expected 1b", conv_output[0][1][0]);
    end
    checks++;
    if (conv_output[4][4][0] !== 32'h58) begin
      errors++; $display("FAIL ramp_corner44: got %h expected 58", conv_output[4][4][0]);
    end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        checks++;
        if (conv_output[y][x][1] !== 32'd0) begin
          errors++;
          $display("FAIL ramp_ch1(%0d,%0d): got %h expected 0", y, x, conv_output[y][x][1]);
        end
        checks++;
        if (conv_output[y][x][0] !== ref_elem(y, x, 0)) begin
          errors++;
          $display("FAIL ramp_ch0(%0d,%0d): got %h expected %h", y, x, conv_output[y][x][0], ref_elem(y, x, 0));
        end
      end
  endtask

  task automatic test_mid_reset();
    logic [31:0] e;
    set_ramp();
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++) begin
          e = (y < 2) ? ref_elem(y, x, o) : 32'd0;
          checks++;
          if (conv_output[y][x][o] !== e) begin
            errors++;
            $display("FAIL mid_two_rows(%0d,%0d,%0d): got %h expected %h", y, x, o, conv_output[y][x][o], e);
          end
        end
    #2 reset = 1'b1;
    #1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++) begin
          checks++;
          if (conv_output[y][x][o] !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_clear(%0d,%0d,%0d): got %h expected 0", y, x, o, conv_output[y][x][o]);
          end
        end
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++) begin
          e = (y == 0) ? ref_elem(y, x, o) : 32'd0;
          checks++;
          if (conv_output[y][x][o] !== e) begin
            errors++;
            $display("FAIL mid_restart(%0d,%0d,%0d): got %h expected %h", y, x, o, conv_output[y][x][o], e);
          end
        end
  endtask

  task automatic test_quant();
    set_ramp();
    quantization_threshold = 32'd100;
    m = 32'd2;
    repeat (H) @(posedge clk);
    #1;
    checks++;
    if (conv_output[2][2][0] !== 32'h1d) begin
      errors++; $display("FAIL quant_center: got %h expected 1d", conv_output[2][2][0]);
    end
    checks++;
    if (conv_output[0][0][0] !== 32'h10) begin
      errors++; $display("FAIL quant_corner: got %h expected 10", conv_output[0][0][0]);
    end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++) begin
          checks++;
          if (conv_output[y][x][o] !== ref_elem(y, x, o)) begin
            errors++;
            $display("FAIL quant(%0d,%0d,%0d): got %h expected %h", y, x, o, conv_output[y][x][o], ref_elem(y, x, o));
          end
        end
  endtask

  task automatic test_saturate();
    for (int j = 0; j < H; j++)
      for (int k = 0; k < W; k++)
        input_activations[0][j][k][0] = 32'hFFFF_FFFF;
    for (int ky = 0; ky < KH; ky++)
      for (int kx = 0; kx < KW; kx++)
        for (int o = 0; o < CO; o++)
          weights[ky][kx][0][o] = 32'hFFFF_FFFF;
    quantization_threshold = 32'hFFFF_FFFF;
    m = 32'd0;
    repeat (H) @(posedge clk);
    #1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++) begin
          checks++;
          if (conv_output[y][x][o] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL saturate(%0d,%0d,%0d): got %h expected ffffffff", y, x, o, conv_output[y][x][o]);
          end
        end
  endtask

  task automatic test_padding();
    logic [31:0] e;
    for (int j = 0; j < H; j++)
      for (int k = 0; k < W; k++)
        input_activations[0][j][k][0] = 32'd0;
    input_activations[0][0][0][0] = 32'd7;
    for (int ky = 0; ky < KH; ky++)
      for (int kx = 0; kx < KW; kx++)
        for (int o = 0; o < CO; o++)
          weights[ky][kx][0][o] = 32'd0;
    weights[KH/2][KW/2][0][0] = 32'd3;
    quantization_threshold = 32'hFFFF_FFFF;
    m = 32'd0;
    repeat (H) @(posedge clk);
    #1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++) begin
          e = (y == 0 && x == 0 && o == 0) ? 32'd21 : 32'd0;
          checks++;
          if (conv_output[y][x][o] !== e) begin
            errors++;
            $display("FAIL padding(%0d,%0d,%0d): got %h expected %h", y, x, o, conv_output[y][x][o], e);
          end
        end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      set_random(it[0]);
      repeat (H) @(posedge clk);
      #1;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          for (int o = 0; o < CO; o++) begin
            checks++;
            if (conv_output[y][x][o] !== ref_elem(y, x, o)) begin
              errors++;
              $display("FAIL random%0d(%0d,%0d,%0d): got %h expected %h", it, y, x, o, conv_output[y][x][o], ref_elem(y, x, o));
            end
          end
    end
  endtask

  task automatic test_frame_done();
    logic e;
    do_reset();
    for (int i = 0; i < 3 * H; i++) begin
      @(posedge clk);
      #1;
      e = ((i + 1) % H) == 0;
      checks++;
      if (frame_done !== e) begin
        errors++;
        $display("FAIL frame_done_cycle%0d: got %b expected %b", i, frame_done, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    set_random(1'b0);
    do_reset();
    repeat (H + 2) @(posedge clk);
    #1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < CO; o++)
          exp_old[y][x][o] = ref_elem(y, x, o);
    set_random_acts(1'b0);
    for (int step = 0; step < 2; step++) begin
      @(posedge clk);
      #1;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          for (int o = 0; o < CO; o++) begin
            e = (y >= 2 && y <= 2 + step) ? ref_elem(y, x, o) : exp_old[y][x][o];
            checks++;
            if (conv_output[y][x][o] !== e) begin
              errors++;
              $display("FAIL b2b_step%0d(%0d,%0d,%0d): got %h expected %h", step, y, x, o, conv_output[y][x][o], e);
            end
          end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_ramp();
    #12;
    checks++;
    if (frame_done !== 1'b0 || conv_output[0][0][0] !== 32'd0) begin
      errors++;
      $display("FAIL initial_reset: frame_done=%b out000=%h expected 0/0", frame_done, conv_output[0][0][0]);
    end
    test_reset();
    test_ramp();
    test_mid_reset();
    test_quant();
    test_saturate();
    test_padding();
    test_random();
    test_frame_done();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv2d_pe.md
Name: conv2d_pe

Overview:
- 2-D convolution processing element: stride 1, zero "same" padding, over an activation tile of Hout x Wout x Cin.
- Computes Cout output feature maps of the same spatial size using a Kh x Kw x Cin x Cout weight tensor.
- Applies a threshold-triggered overflow reduction: right-shift by m, then saturate.
- Free-running: computes one output row per clock and loops over the frame continuously. It is the compute leaf of the accelerator datapath.

Parameters:
- N, 1, batch size of the activation port; only batch index 0 is convolved.
- Hout, 5, input and output height.
- Wout, 5, input and output width.
- Cin, 1, input channels.
- Cout, 2, output channels.
- Kh, 3, kernel height (odd).
- Kw, 3, kernel width (odd).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- input_activations  input  32 x [N][Hout][Wout][Cin]  unsigned activations, unpacked array.
- weights  input  32 x [Kh][Kw][Cin][Cout]  unsigned weights, unpacked array.
- quantization_threshold  input  32  unsigned overflow threshold.
- m  input  32  overflow right-shift amount; only m[5:0] is used.
- conv_output  output  32 x [Hout][Wout][Cout]  registered results, unpacked array.
- frame_done  output  1  one-cycle pulse when the last row of a frame is written.

Behaviour:
- Reset (async assert): all conv_output elements = 0, frame_done = 0, row counter = 0, FSM = COMPUTE. Reset asserted mid-frame aborts the frame and clears all outputs.
- FSM states:
  - COMPUTE: on each rising edge, row r is written for all Wout x Cout elements, then r increments.
  - When r = Hout-1: write the row, pulse frame_done, wrap r to 0, stay in COMPUTE.
  - There is no idle state and no start handshake.
- Inputs are sampled combinationally in the cycle a row is computed, so input changes take effect on the next row computed.
- Latency: row r is valid after the (r+1)-th rising edge following reset deassertion. A full frame takes Hout cycles.
- Rows not yet rewritten hold their previous value.
- Element (y,x,co) = sum over ky<Kh, kx<Kw, ci<Cin of A[0][y+ky-Kh/2][x+kx-Kw/2][ci] * W[ky][kx][ci][co].
  - Out-of-range coordinates contribute 0 (zero padding).
- Arithmetic:
  - 32x32 unsigned products, 64 bits wide.
  - Accumulator width = 64 + clog2(Kh*Kw*Cin) bits.
- Quantize:
  - If acc > zero-extended quantization_threshold: q = acc >> m[5:0].
  - Otherwise: q = acc.
  - Output = q saturated to 32'hFFFFFFFF if q exceeds 32 bits.
  - acc equal to the threshold is not shifted.
  - m = 0 with acc above threshold gives saturate-only.
- Boundaries:
  - Corners see (Kh/2+1)*(Kw/2+1) valid taps; edges see partial windows.
  - Hout = 1 gives frame_done high every cycle after reset.

Optional Feature:
- Macro: CONV2D_PE_SIGNED_EN.
- With the macro defined:
  - Activations and weights are two's-complement.
  - Products and accumulation are signed.
  - Threshold comparison uses the absolute value of acc.
  - Shift is arithmetic.
  - Saturation clamps to 32'h7FFFFFFF / 32'h80000000.
- Without it: all arithmetic is unsigned, as above.

Decomposition:
- Package conv2d_pe_pkg holds:
  - DATA_W = 32 constant.
  - data_t (logic [31:0]) typedef.
  - Accumulator typedef sized from the parameters via a function.
  - State enum (COMPUTE).
  - Saturation/quantize function.
- One sub-module, conv2d_pe_dot: combinational Kh*Kw*Cin-tap dot product with padding masks plus quantization. It is instantiated Wout x Cout times per row.

Test Plan:
- Activations A[0][j][k][0] = 1 + 5j + k; channel 0 weights all 1, channel 1 weights all 0. After 6 cycles:
  - (2,2,0) = 0x75
  - (0,0,0) = 0x10
  - (0,1,0) = 0x1b
  - (4,4,0) = 0x58
  - every (*,*,1) = 0
- Reset asserted mid-frame (after 2 rows written) -> all outputs 0 immediately; rows are recomputed from row 0 after release.
- Threshold = 100, m = 2, same stimulus:
  - (2,2,0) = 117 >> 2 = 0x1d
  - (0,0,0) = 0x10, unchanged
- All activations and weights 0xFFFFFFFF, threshold 0xFFFFFFFF, m = 0 -> every element saturates to 0xFFFFFFFF.
- Single nonzero activation A[0][0][0][0] = 7, kernel with only center tap = 3 -> (0,0,0) = 21; all other elements 0. This checks padding alignment.
- frame_done pulses exactly once per Hout cycles; an activation change is reflected on the next computed row only.
